csa_accum: RTL

//   Parametrised carry-save accumulator, successor to the fixed 80-bit 3:2 CSA row.
//   - Absorbs a frame of WIDTH-bit operands, one per accepted beat, into redundant
//     sum/carry registers. There is no carry propagation per beat.
//   - At frame end it resolves once with a carry-propagate add.
//   - It presents the mod-2^WIDTH total on a valid/ready output.
//   - Sits after the partial-product stages of the wide multipliers.

---
 rtl/csa_accum.sv | 105 ++++++++++
 1 files changed

// File: rtl/csa_accum.sv
// Carry-save frame accumulator: redundant per-beat absorb, one resolving add per frame.
// Optional overflow count on out_hi when CSA_ACC_OVF_EN is defined.
module csa_accum #(
  parameter int WIDTH = 80,
  parameter int CNT_W = 8,
  parameter int HI_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CSA_ACC_OVF_EN
  output logic [HI_W-1:0]  out_hi,
`endif
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic [1:0] {
    ACC,
    RESOLVE,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] sn;
  logic [WIDTH-1:0] cn;
  logic [WIDTH-1:0] maj;
  logic [WIDTH:0]   res;
  logic [CNT_W-1:0] cnt;
  logic             xfer;

  assign in_ready = (state == ACC);
  assign xfer     = in_valid && in_ready;

  // 3:2 compression; maj[WIDTH-1] is the carry that falls off the top
  assign maj = (s_reg & c_reg) | (s_reg & in_data) | (c_reg & in_data);
  assign sn  = s_reg ^ c_reg ^ in_data;
  assign cn  = {maj[WIDTH-2:0], 1'b0};
  assign res = {1'b0, s_reg} + {1'b0, c_reg};

`ifdef CSA_ACC_OVF_EN
  logic [HI_W-1:0] hi;
`else
  logic unused_ovf;
  assign unused_ovf = maj[WIDTH-1] ^ res[WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      s_reg     <= '0;
      c_reg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
`ifdef CSA_ACC_OVF_EN
      hi        <= '0;
      out_hi    <= '0;
`endif
    end else begin
      unique case (state)
        ACC: begin
          if (xfer) begin
            s_reg <= sn;
            c_reg <= cn;
            if (cnt != '1) cnt <= cnt + 1'b1;
`ifdef CSA_ACC_OVF_EN
            hi    <= hi + maj[WIDTH-1];
`endif
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum   <= res[WIDTH-1:0];
          out_beats <= cnt;
`ifdef CSA_ACC_OVF_EN
          out_hi    <= hi + res[WIDTH];
          hi        <= '0;
`endif
          s_reg     <= '0;
          c_reg     <= '0;
          cnt       <= '0;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
